onehot_issuer: RTL
==================

# onehot_issuer

Transmit-side counterpart of the one-hot latch accumulator. On `start`, it issues every bit index of a WIDTH-bit vector exactly once as a single-hot word over a valid/ready handshake. It tracks the issued mask and asserts `done` once the mask is all ones. One dependent index may only be issued after at least one of its three prerequisite indices has been issued; the block defers it when necessary. It drives any consumer that ORs one-hot words into a latch, so that consumer's constraints hold by construction.

## Interface
- WIDTH, 16, vector width; must be ≥ 4.
- DEP_BIT, 9, index that needs a prerequisite before it is issued.
- PRE0, 12, first prerequisite index.
- PRE1, 13, second prerequisite index.
- PRE2, 14, third prerequisite index.
- All indices must be < WIDTH. PRE0, PRE1 and PRE2 must each differ from DEP_BIT.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a new issue sequence; ignored while busy.
- x_ready  input  1  consumer accepts `x` this cycle.
- x  output  WIDTH  one-hot word; all zeros when `x_valid`=0.
- x_valid  output  1  `x` is valid.
- issued  output  WIDTH  OR of all accepted words since the last start.
- busy  output  1  high in SCAN or DEFER.
- done  output  1  level; high in DONE.

## Operation
- State is IDLE, SCAN, DEFER or DONE. Registers are `idx` ($clog2(WIDTH) bits), `pending` and `issued`. All outputs are registered or decoded from state.
- prereq_ok = `issued[PRE0] | issued[PRE1] | issued[PRE2]`.
- IDLE, or DONE, with `start`=1: clear `issued`, set `idx`=0, clear `pending`, go to SCAN.
- SCAN, skip case (`idx`==DEP_BIT and !prereq_ok):
  - `x_valid`=0 for that cycle.
  - set `pending`=1 and advance `idx`.
- SCAN, all other cases:
  - `x_valid`=1, `x`=1<<`idx`.
  - On handshake (`x_valid`&`x_ready`): `issued` |= `x`, then `idx`++.
- When the step at `idx`==WIDTH-1 completes (handshake, or skip when DEP_BIT is the top index): go to DEFER if `pending`, otherwise to DONE. `idx` does not wrap.
- DEFER:
  - `x_valid`=1, `x`=1<<DEP_BIT. prereq_ok is guaranteed true here, because the scan is ascending and skipping occurs only when every prerequisite index is above DEP_BIT.
  - On handshake: set the bit, clear `pending`, go to DONE.
- DONE: `done`=1, `x_valid`=0, `issued` is all ones. Stay until `start`.
- Handshake rule: once `x_valid` is high, `x` and `x_valid` hold unchanged until `x_ready`. Backpressure stalls the sequence indefinitely without loss or duplication.
- `start` during SCAN or DEFER has no effect.
- `rst` asserted at any time forces IDLE immediately, even mid-sequence, with `issued`, `idx` and `pending` cleared.

## Timing
- Reset values: `x`=0, `x_valid`=0, `issued`=0, `busy`=0, `done`=0.
- `start` sampled at edge k: `busy` and the first `x_valid` appear in cycle k+1.
- With `x_ready` held high and no skip: handshakes in cycles k+1..k+WIDTH, `done`=1 from k+WIDTH+1.
- With a skip: one idle cycle at the DEP_BIT position, DEFER handshake at k+WIDTH+1, `done`=1 from k+WIDTH+2.
- Each cycle of `x_ready`=0 while `x_valid`=1 adds exactly one cycle to these figures.
- `issued` updates on the edge that completes a handshake and is visible the following cycle.

## Configuration
- ONEHOT_ISSUER_DEP_EN
  - Defined: dependency enforcement, skip and DEFER behave as above.
  - Undefined: DEFER is never entered, `pending` is constant 0, and the sequence is strictly ascending 0..WIDTH-1. `done` comes at k+WIDTH+1 regardless of DEP_BIT/PRE*.

## Test plan
- Defaults, macro defined, `x_ready`=1, `start` at edge 0:
  - `x` sequence is 0..8, idle cycle, 10..15, 9.
  - `done` rises in cycle 18 with `issued`=16'hFFFF.
- PRE2=3, macro defined: no skip, strictly ascending, `done` in cycle 17.
- Macro undefined, defaults: strictly ascending, `done` in cycle 17, no cycle with `x_valid`=0 between cycles 1 and 16.
- `x_ready` deasserted for 3 cycles while `x`=16'h0020:
  - `x` and `x_valid` are held.
  - `issued[5]` sets only after acceptance; `done` is delayed by 3 cycles.
- `rst` pulsed while `idx`=7:
  - All outputs are 0 asynchronously.
  - A following `start` restarts from index 0.
- `start` pulsed mid-SCAN is ignored. `start` in DONE clears `issued` and begins a new sequence in the next cycle.

Source files
------------

// File: rtl/onehot_issuer.sv
// onehot_issuer: issues each bit index once as a one-hot word over valid/ready; ONEHOT_ISSUER_DEP_EN enables the DEP_BIT prerequisite deferral.
module onehot_issuer #(
  parameter int WIDTH   = 16,
  parameter int DEP_BIT = 9,
  parameter int PRE0    = 12,
  parameter int PRE1    = 13,
  parameter int PRE2    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             x_ready,
  output logic [WIDTH-1:0] x,
  output logic             x_valid,
  output logic [WIDTH-1:0] issued,
  output logic             busy,
  output logic             done
);
`ifdef ONEHOT_ISSUER_DEP_EN
  localparam bit DEP_EN = 1'b1;
`else
  localparam bit DEP_EN = 1'b0;
`endif
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH-1);
  localparam logic [IW-1:0] DEP = IW'(DEP_BIT);
  typedef enum logic [1:0] {IDLE, SCAN, DEFER, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic pending, pending_n;
  logic [WIDTH-1:0] issued_n;
  logic prereq_ok, skip;
  assign prereq_ok = issued[PRE0] | issued[PRE1] | issued[PRE2];
  assign skip = DEP_EN && state == SCAN && idx == DEP && !prereq_ok;
  assign busy = state == SCAN || state == DEFER;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
      issued  <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pending <= pending_n;
      issued  <= issued_n;
    end
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pending_n = pending;
    issued_n  = issued;
    x_valid   = 1'b0;
    x         = '0;
    case (state)
      IDLE, DONE: if (start) begin
        state_n   = SCAN;
        idx_n     = '0;
        pending_n = 1'b0;
        issued_n  = '0;
      end
      SCAN: begin
        x_valid   = !skip;
        x         = skip ? '0 : WIDTH'(1) << idx;
        pending_n = pending | skip;
        // a skip completes the step without a handshake; idx saturates at the top index
        if (skip || x_ready) begin
          issued_n = issued | x;
          idx_n    = idx == LAST ? idx : idx + 1'b1;
          if (idx == LAST) state_n = pending_n ? DEFER : DONE;
        end
      end
      DEFER: begin
        x_valid = 1'b1;
        x       = WIDTH'(1) << DEP_BIT;
        if (x_ready) begin
          issued_n  = issued | x;
          pending_n = 1'b0;
          state_n   = DONE;
        end
      end
      default: ;
    endcase
  end
endmodule
